// File: rtl/tqvp_textbuf_console.sv
// Text buffer console peripheral: DEPTH-character buffer with a cursor, plus
// hardware CLEAR/SCROLL sequencers that raise a level interrupt when they finish.
module tqvp_textbuf_console #(
    parameter int COLS = 16,
    parameter int ROWS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW-1:0] LAST       = AW'(DEPTH - 1);
    localparam logic [AW-1:0] MOVE_LAST  = AW'(DEPTH - COLS - 1);
    localparam logic [AW-1:0] COLS_A     = AW'(COLS);
    localparam logic [AW-1:0] BOTTOM_ROW = AW'((ROWS - 1) * COLS);

    localparam logic [5:0] A_CURSOR = 6'h00;
    localparam logic [5:0] A_CHAR   = 6'h01;
    localparam logic [5:0] A_CMD    = 6'h02;
    localparam logic [5:0] A_STATUS = 6'h03;
    localparam logic [5:0] A_FILL   = 6'h04;
    localparam logic [5:0] A_IRQ    = 6'h08;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCROLL_MOVE, S_SCROLL_FILL} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cur_q;
    logic [AW-1:0]   idx_q;
    logic            wrap_q;
    logic            irq_q;
    logic [7:0]      fill_q;
    logic [7:0]      text_mem [DEPTH];

    logic            wr;
    logic            busy;
    logic            done;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_wdata;
    logic            unused_inputs;

    assign wr             = (data_write_n != 2'b11);
    assign unused_inputs  = &{1'b0, ui_in, data_read_n, data_in[31:8]};
    assign uo_out         = text_mem[cur_q];
    assign data_ready     = 1'b1;
    assign user_interrupt = irq_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wr && address == A_CMD) begin
                    if (data_in[0])      state_d = S_CLEAR;
                    else if (data_in[1]) state_d = S_SCROLL_MOVE;
                end
            end
            S_CLEAR:       if (idx_q == LAST)      state_d = S_IDLE;
            S_SCROLL_MOVE: if (idx_q == MOVE_LAST) state_d = S_SCROLL_FILL;
            S_SCROLL_FILL: if (idx_q == LAST)      state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // One buffer write port, shared by CPU character writes and the sequencers
    always_comb begin
        busy      = 1'b1;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = idx_q;
        mem_wdata = fill_q;
        case (state_q)
            S_IDLE: begin
                busy      = 1'b0;
                mem_addr  = cur_q;
                mem_wdata = data_in[7:0];
                mem_we    = wr && (address == A_CHAR);
            end
            S_CLEAR: begin
                mem_we = 1'b1;
                done   = (idx_q == LAST);
            end
            S_SCROLL_MOVE: begin
                mem_we    = 1'b1;
                mem_wdata = text_mem[idx_q + COLS_A];
            end
            S_SCROLL_FILL: begin
                mem_we = 1'b1;
                done   = (idx_q == LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q  <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
            irq_q  <= 1'b0;
            fill_q <= 8'h20;
        end else begin
            idx_q <= (busy && !done) ? idx_q + 1'b1 : '0;
            if (!busy && wr) begin
                case (address)
                    A_CURSOR: if ({1'b0, data_in[7:0]} < 9'(DEPTH)) cur_q <= data_in[AW-1:0];
                    A_CHAR: begin
                        if (cur_q == LAST) begin
                            cur_q  <= '0;
                            wrap_q <= 1'b1;
                        end else begin
                            cur_q <= cur_q + 1'b1;
                        end
                    end
                    A_FILL:  fill_q <= data_in[7:0];
                    default: ;
                endcase
            end
            if (wr && address == A_STATUS && data_in[1]) wrap_q <= 1'b0;
            if (done) cur_q <= (state_q == S_CLEAR) ? '0 : BOTTOM_ROW;
            // Completion outranks a simultaneous software clear
            if (done)                                   irq_q <= 1'b1;
            else if (wr && address == A_IRQ && data_in[0]) irq_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) text_mem[mem_addr] <= mem_wdata;
    end

    always_comb begin
        data_out = '0;
        case (address)
            A_CURSOR: data_out[AW-1:0] = cur_q;
            A_CHAR:   data_out[7:0]    = text_mem[cur_q];
            A_STATUS: data_out[2:0]    = {irq_q, wrap_q, busy};
            A_FILL:   data_out[7:0]    = fill_q;
            default:  ;
        endcase
    end

endmodule
